// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory request,
// PC+4 generation and the IF/ID pipeline register.
//
// Handshake: Imem_req is asserted while the stage wants a word at Imem_addr.
// A word is taken on a rising edge only when Imem_req and Imem_ready are both
// high and no Flush is present. Imem_req depends only on state and Stall, so
// there is no path from Imem_ready back into the request.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Next_addr,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Imem_ready,
  input  logic [31:0] Imem_rdata,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  output logic [31:0] PC_Add4,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_Valid,
  output logic [31:0] Fetch_count,
  output logic        State_dbg
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic        accept;

  assign PC_Add4     = pc_q + 32'd4;
  assign Imem_addr   = pc_q;
  assign IF_ID_PC4   = pc4_q;
  assign IF_ID_Instr = instr_q;
  assign IF_ID_Valid = valid_q;
  assign Fetch_count = count_q;
  assign State_dbg   = state_q;

  // Next-state and request logic; priority is Flush > Stall > accept > wait.
  always_comb begin
    state_d  = RUN;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    count_d  = count_q;
    Imem_req = (state_q == RUN) && !Stall;
    accept   = Imem_req && Imem_ready && !Flush;

    if (Flush) begin
      // Redirect and kill whatever sits in IF/ID; a same-cycle reply is dropped.
      pc_d    = Next_addr;
      instr_d = NOP_INSTR;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (Stall) begin
      // Everything holds.
    end else if (accept) begin
      pc_d    = Next_addr;
      instr_d = Imem_rdata;
      pc4_d   = PC_Add4;
      valid_d = 1'b1;
      count_d = count_q + 32'd1;
    end else if (state_q == RUN) begin
      // Memory not ready: keep the address, push a bubble downstream.
      instr_d = NOP_INSTR;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

endmodule
